serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits; legal range 2..16.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  request; sampled on rising clk, honoured only in IDLE.
REQ-005 A  input  WIDTH  minuend (unsigned); captured on the accepted start edge only.
REQ-006 B  input  WIDTH  subtrahend (unsigned); captured on the accepted start edge only.
REQ-007 busy  output  1  high while in SHIFT or DONE.
REQ-008 done  output  1  one-cycle pulse; high exactly in the DONE cycle.
REQ-009 diff  output  WIDTH  registered result A-B mod 2^WIDTH.
REQ-010 bout  output  1  registered final borrow; 1 iff A < B (unsigned).

Function
REQ-011 FSM states: IDLE, SHIFT, DONE; binary encoded, no other reachable states.
REQ-012 IDLE: start=1 loads a_sh<=A, b_sh<=B, borrow<=0, count<=0, work<=0, goes to SHIFT; start=0 stays in IDLE.
REQ-013 SHIFT, each cycle: d = a_sh[0]^b_sh[0]^borrow; borrow <= (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&borrow).
REQ-014 SHIFT, each cycle: a_sh, b_sh shift right one bit; d enters work at the MSB; count increments by 1.
REQ-015 SHIFT lasts exactly WIDTH cycles; on the cycle with count==WIDTH-1, diff<=final work and bout<=final borrow load; next state DONE.
REQ-016 DONE lasts exactly one cycle, then IDLE unconditionally.
REQ-017 Latency: start accepted at edge k -> done high during the cycle after edge k+WIDTH; new start accepted no earlier than edge k+WIDTH+2.
REQ-018 diff and bout change only at the REQ-015 load; they hold their value through IDLE and through the next computation until its load.
REQ-019 start in SHIFT or DONE: ignored; no state, operand or output changes; no queuing.
REQ-020 A and B changes after the accepted edge: no effect on the computation in progress.
REQ-021 Arithmetic: modulo 2^WIDTH; no sign interpretation; bout is the only overflow indication.
REQ-022 Boundary: A==B -> diff=0, bout=0; B==0 -> diff=A, bout=0; A=0, B=1 -> diff=all ones, bout=1.

Reset
REQ-023 rst=1 forces, asynchronously: state=IDLE, busy=0, done=0, diff=0, bout=0, borrow=0, count=0, a_sh=b_sh=work=0.
REQ-024 rst asserted mid-SHIFT or in DONE: computation aborted; no done pulse; diff/bout read 0.
REQ-025 After rst deassertion: first start is accepted on the first rising edge where rst=0 and start=1.

Structure
REQ-026 Shared package holds the WIDTH default, the state encoding constants and the count width (clog2 of WIDTH).
REQ-027 Per-bit arithmetic is a separate sub-module one_bit_full_subtractor (a, b, bin -> d, bout), instantiated once.
REQ-028 The sub-module is purely combinational; the borrow flip-flop is in serial_subtractor.
REQ-029 No combinational path from start, A or B to any output.

Verification (WIDTH=4)
REQ-030 A=9, B=3, start pulse -> done in the 5th cycle after the accepted edge; diff=6, bout=0; busy high 5 cycles.
REQ-031 A=3, B=9 -> diff=0xA, bout=1; A=0, B=1 -> diff=0xF, bout=1; A=15, B=0 -> diff=0xF, bout=0; A=7, B=7 -> diff=0, bout=0.
REQ-032 start held high continuously with A=5, B=2, then A=1, B=4 -> results 3/0 then 0xD/1; back-to-back period 6 cycles; inputs changed mid-operation have no effect.
REQ-033 rst pulse asserted mid-SHIFT -> busy=0, done=0, diff=0, bout=0 immediately; next start with A=8, B=1 -> diff=7, bout=0.
REQ-034 Exhaustive 256-pair sweep -> diff=(A-B)&0xF and bout=(A<B) for every pair; exactly one done pulse per accepted start.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: default width, FSM encoding
// and the helper that sizes the bit counter.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Counter width is clog2(width), never narrower than one bit.
  function automatic int count_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  localparam int DEFAULT_CNT_W = count_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_subtractor_fs.sv
// Combinational one-bit full subtractor: d = a - b - bin, with borrow out.
module one_bit_full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: LSB-first over WIDTH cycles, registered
// difference and final borrow, one-cycle done pulse.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int             CNT_W = count_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_work;
  logic               r_borrow;
  logic [CNT_W-1:0]   r_count;
  logic               w_d;
  logic               w_borrow_next;
  logic               w_last;

  assign w_last = (r_count == LAST_BIT);

  one_bit_full_subtractor u_fs (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_borrow_next)
  );

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: defaulting to the current state before the case keeps this block
  // purely combinational; a missing assignment would infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_SHIFT;
      ST_SHIFT: if (w_last) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Outputs decode the state register only, so start/A/B never reach them.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_SHIFT: busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_work   <= '0;
      r_borrow <= 1'b0;
      r_count  <= '0;
      diff     <= '0;
      bout     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sh   <= A;
            r_b_sh   <= B;
            r_work   <= '0;
            r_borrow <= 1'b0;
            r_count  <= '0;
          end
        end
        ST_SHIFT: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_work   <= {w_d, r_work[WIDTH-1:1]};
          r_borrow <= w_borrow_next;
          r_count  <= r_count + 1'b1;
          // Result is published once, on the last bit, and held until the next load.
          if (w_last) begin
            diff <= {w_d, r_work[WIDTH-1:1]};
            bout <= w_borrow_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, back-to-back
// starts, mid-operation reset and an exhaustive 4-bit sweep via a scoreboard.
module tb_serial_subtractor;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_tests;
  int           n_fail;
  int           n_started;
  int           n_done;
  logic [W-1:0] last_diff;
  logic         last_bout;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every done pulse must consume exactly one expected result.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      n_done++;
      check("sb_has_entry", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("diff", diff, mon_e.diff);
        check("bout", bout, mon_e.bout);
      end
    end
  end

  // Called at a negedge while the DUT is idle; returns at a negedge in the
  // following idle cycle. keep=1 leaves start high and loads next operands.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit keep, input logic [W-1:0] na, input logic [W-1:0] nb);
    exp_t       e;
    logic [W:0] t;
    t      = {1'b0, a} - {1'b0, b};
    e.diff = t[W-1:0];
    e.bout = (a < b);
    start  = 1'b1;
    A      = a;
    B      = b;
    sb.push_back(e);
    n_started++;
    for (int c = 1; c <= W + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (keep) begin
          A = na;
          B = nb;
        end else begin
          start = 1'b0;
          A = W'($urandom);
          B = W'($urandom);
        end
      end
      check("busy_active", busy, 1);
      check("done_timing", done, (c == W + 1));
      if (c <= W) begin
        check("diff_hold", diff, last_diff);
        check("bout_hold", bout, last_bout);
      end
    end
    last_diff = e.diff;
    last_bout = e.bout;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_diff_hold", diff, last_diff);
    check("idle_bout_hold", bout, last_bout);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    n_started = 0;
    n_done    = 0;
    last_diff = '0;
    last_bout = 1'b0;
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;

    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_start_busy", busy, 0);

    // Basic and boundary cases.
    run_op(4'd9,  4'd3, 1'b0, 4'd0, 4'd0);
    run_op(4'd3,  4'd9, 1'b0, 4'd0, 4'd0);
    run_op(4'd0,  4'd1, 1'b0, 4'd0, 4'd0);
    run_op(4'd15, 4'd0, 1'b0, 4'd0, 4'd0);
    run_op(4'd7,  4'd7, 1'b0, 4'd0, 4'd0);

    // start held high: back-to-back with operands changed mid-operation.
    run_op(4'd5, 4'd2, 1'b1, 4'd1, 4'd4);
    run_op(4'd1, 4'd4, 1'b0, 4'd0, 4'd0);

    // Reset in the middle of SHIFT aborts the computation.
    start = 1'b1;
    A     = 4'd12;
    B     = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_bout", bout, 0);
    @(negedge clk);
    rst       = 1'b0;
    last_diff = '0;
    last_bout = 1'b0;
    run_op(4'd8, 4'd1, 1'b0, 4'd0, 4'd0);

    // Exhaustive sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(W'(a), W'(b), 1'b0, 4'd0, 4'd0);
      end
    end

    repeat (3) @(negedge clk);
    check("done_count", n_done, n_started);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
